// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the quad 2-input gate tester.
// Optional feature macro: GATE_TEST_SYNC_EN (see gate_quad_tester.sv).
package gate_test_pkg;

    localparam int unsigned GATE_W = 4;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_NAND = 2'd1;
    localparam logic [1:0] OP_OR   = 2'd2;
    localparam logic [1:0] OP_XOR  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Expected outputs of all four gates for the selected function.
    function automatic logic [GATE_W-1:0] expected_y(
        input logic [1:0]        op,
        input logic [GATE_W-1:0] a,
        input logic [GATE_W-1:0] b
    );
        logic [GATE_W-1:0] y;
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
        return y;
    endfunction

    // B vector is the step rotated by two, so gate i pairs s[i] with s[(i+2)%4].
    function automatic logic [GATE_W-1:0] b_from_step(input logic [GATE_W-1:0] s);
        return {s[1:0], s[3:2]};
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for four 2-input gates of the selected function.
module gate_ref_model
    import gate_test_pkg::*;
(
    input  logic [1:0]        i_op,
    input  logic [GATE_W-1:0] i_a,
    input  logic [GATE_W-1:0] i_b,
    output logic [GATE_W-1:0] o_y_exp
);

    always_comb begin
        o_y_exp = expected_y(i_op, i_a, i_b);
    end

endmodule

// File: rtl/gate_quad_tester.sv
// Sweeps 16 vectors over a quad 2-input gate and reports pass/fail with per-gate mask.
// Define GATE_TEST_SYNC_EN to pass dut_y through a 2-flop synchronizer (needs SETTLE_CYC >= 2).
module gate_quad_tester
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    output logic [GATE_W-1:0] dut_a,
    output logic [GATE_W-1:0] dut_b,
    input  logic [GATE_W-1:0] dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [GATE_W-1:0] fail_mask,
    output logic [GATE_W-1:0] fail_step
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle_range
        $error("gate_quad_tester: SETTLE_CYC must be in 1..15");
    end

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t            r_state;
    logic [GATE_W-1:0] r_step;
    logic [3:0]        r_cnt;
    logic [1:0]        r_op;
    logic [GATE_W-1:0] w_y;
    logic [GATE_W-1:0] w_y_exp;
    logic [GATE_W-1:0] w_mism;
    logic [GATE_W-1:0] w_step_next;

`ifdef GATE_TEST_SYNC_EN
    if (SETTLE_CYC < 2) begin : g_bad_settle_sync
        $error("gate_quad_tester: SETTLE_CYC must be >= 2 with GATE_TEST_SYNC_EN");
    end

    logic [GATE_W-1:0] r_y_meta;
    logic [GATE_W-1:0] r_y_sync;

    // Synchronizer refills during SETTLE, so CHECK sees the settled vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_meta <= '0;
            r_y_sync <= '0;
        end else begin
            r_y_meta <= dut_y;
            r_y_sync <= r_y_meta;
        end
    end

    assign w_y = r_y_sync;
`else
    assign w_y = dut_y;
`endif

    gate_ref_model u_ref (
        .i_op    (r_op),
        .i_a     (dut_a),
        .i_b     (dut_b),
        .o_y_exp (w_y_exp)
    );

    assign w_mism      = w_y ^ w_y_exp;
    assign w_step_next = r_step + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_cnt     <= '0;
            r_op      <= OP_AND;
            dut_a     <= '0;
            dut_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            fail_step <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_step    <= '0;
                        dut_a     <= '0;
                        dut_b     <= '0;
                        fail_mask <= '0;
                        fail_step <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_cnt   <= SETTLE_LOAD;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    fail_mask <= fail_mask | w_mism;
                    if (w_mism != '0 && fail_mask == '0) begin
                        fail_step <= r_step;
                    end
                    // Next vector is driven on the same edge that enters DRIVE.
                    if (r_step == 4'd15) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_step  <= w_step_next;
                        dut_a   <= w_step_next;
                        dut_b   <= b_from_step(w_step_next);
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    pass    <= (fail_mask == '0);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
